// File: rtl/ir_code_tx.sv
// Pulse-distance IR transmitter: maps a button code to its raw 32-bit IR word and
// sends leader, 32 LSB-first data bits and a stop mark, optionally carrier-modulated.
module ir_code_tx #(
  parameter int UNIT_CYCLES  = 28125,  // clk cycles per timing unit, >= 2
  parameter int CARRIER_HALF = 658,    // clk cycles per carrier half-period, >= 1
  parameter bit CARRIER_EN   = 1'b1,
  parameter int GAP_UNITS    = 16      // idle units after the stop mark, >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_valid,
  output logic        btn_ready,
  input  logic [31:0] btn_code,
  output logic        ir_env,
  output logic        ir_tx,
  output logic        busy,
  output logic        frame_done,
  output logic        code_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } state_t;

  localparam int UNIT_W    = $clog2(UNIT_CYCLES);
  localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int DUR_W     = $clog2(MAX_UNITS);
  localparam int CAR_W     = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_word;
  logic [4:0]         r_bit;
  logic [UNIT_W-1:0]  r_unit;
  logic [DUR_W-1:0]   r_units;
  logic [CAR_W-1:0]   r_car_cnt;
  logic               r_car;
  logic               r_code_err;
  logic               r_alive;

  logic               w_accept;
  logic               w_map_ok;
  logic [31:0]        w_map_raw;
  logic [DUR_W-1:0]   w_dur_m1;
  logic               w_unit_end;
  logic               w_state_end;
  logic               w_mark;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_map_ok  = 1'b1;
    w_map_raw = 32'h0;
    case (btn_code)
      32'h1:   w_map_raw = 32'h0000_0A0B;
      32'h2:   w_map_raw = 32'h0000_0A02;
      32'h5:   w_map_raw = 32'h0000_0A04;
      32'h6:   w_map_raw = 32'h0000_0A06;
      32'h7:   w_map_raw = 32'h0000_0A08;
      32'h8:   w_map_raw = 32'h0000_0A10;
      32'h9:   w_map_raw = 32'h0000_0A0A;
      32'hA:   w_map_raw = 32'h0000_0A12;
      default: w_map_ok  = 1'b0;
    endcase
  end

  assign btn_ready = r_alive && (r_state == S_IDLE);
  assign w_accept  = btn_valid && btn_ready;

  // Duration of the current state in units, minus one.
  always_comb begin
    w_dur_m1 = '0;
    case (r_state)
      S_LEAD_MARK:  w_dur_m1 = DUR_W'(15);
      S_LEAD_SPACE: w_dur_m1 = DUR_W'(7);
      S_BIT_SPACE:  w_dur_m1 = r_word[r_bit] ? DUR_W'(2) : DUR_W'(0);
      S_GAP:        w_dur_m1 = DUR_W'(GAP_UNITS - 1);
      default:      w_dur_m1 = '0;
    endcase
  end

  assign w_unit_end  = (r_unit == UNIT_W'(UNIT_CYCLES - 1));
  assign w_state_end = w_unit_end && (r_units == w_dur_m1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_accept && w_map_ok) w_next = S_LEAD_MARK;
      S_LEAD_MARK:  if (w_state_end) w_next = S_LEAD_SPACE;
      S_LEAD_SPACE: if (w_state_end) w_next = S_BIT_MARK;
      S_BIT_MARK:   if (w_state_end) w_next = S_BIT_SPACE;
      S_BIT_SPACE:  if (w_state_end) w_next = (r_bit == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (w_state_end) w_next = S_GAP;
      S_GAP:        if (w_state_end) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_bit      <= '0;
      r_unit     <= '0;
      r_units    <= '0;
      r_code_err <= 1'b0;
      r_alive    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_alive    <= 1'b1;
      r_code_err <= w_accept && !w_map_ok;
      if (w_accept && w_map_ok) begin
        r_word <= w_map_raw;
        r_bit  <= '0;
      end else if (r_state == S_BIT_SPACE && w_state_end && r_bit != 5'd31) begin
        r_bit <= r_bit + 5'd1;
      end
      if (r_state == S_IDLE || w_state_end) begin
        r_unit  <= '0;
        r_units <= '0;
      end else if (w_unit_end) begin
        r_unit  <= '0;
        r_units <= r_units + DUR_W'(1);
      end else begin
        r_unit <= r_unit + UNIT_W'(1);
      end
    end
  end

  assign w_mark = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) || (r_state == S_STOP_MARK);

  // Carrier is held at phase start outside marks, so each mark begins with a full high half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_car     <= 1'b1;
      r_car_cnt <= '0;
    end else if (!w_mark) begin
      r_car     <= 1'b1;
      r_car_cnt <= '0;
    end else if (r_car_cnt == CAR_W'(CARRIER_HALF - 1)) begin
      r_car     <= ~r_car;
      r_car_cnt <= '0;
    end else begin
      r_car_cnt <= r_car_cnt + CAR_W'(1);
    end
  end

  assign ir_env     = w_mark;
  assign ir_tx      = w_mark && (r_car || !CARRIER_EN);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_STOP_MARK) && w_state_end;
  assign code_err   = r_code_err;

endmodule

// File: tb/tb_ir_code_tx.sv
// Self-checking bench for ir_code_tx: a cycle-level envelope/carrier model built from
// the frame rules is compared against the DUT for directed and randomized codes.
module tb_ir_code_tx;
  localparam int UNIT = 4;
  localparam int CH   = 1;
  localparam int GAP  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_valid = 1'b0;
  logic [31:0] btn_code = 32'h0;
  logic        btn_ready, ir_env, ir_tx, busy, frame_done, code_err;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  logic exp_env[$];
  logic exp_tx[$];

  ir_code_tx #(
    .UNIT_CYCLES (UNIT),
    .CARRIER_HALF(CH),
    .CARRIER_EN  (1'b1),
    .GAP_UNITS   (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_valid (btn_valid),
    .btn_ready (btn_ready),
    .btn_code  (btn_code),
    .ir_env    (ir_env),
    .ir_tx     (ir_tx),
    .busy      (busy),
    .frame_done(frame_done),
    .code_err  (code_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] map_code(input logic [31:0] c);
    case (c)
      32'h1:   return {1'b1, 32'h0A0B};
      32'h2:   return {1'b1, 32'h0A02};
      32'h5:   return {1'b1, 32'h0A04};
      32'h6:   return {1'b1, 32'h0A06};
      32'h7:   return {1'b1, 32'h0A08};
      32'h8:   return {1'b1, 32'h0A10};
      32'h9:   return {1'b1, 32'h0A0A};
      32'hA:   return {1'b1, 32'h0A12};
      default: return 33'h0;
    endcase
  endfunction

  // A run of 'units' units at level lvl; marks carry the carrier starting high.
  task automatic push_run(input logic lvl, input int units);
    for (int k = 0; k < units * UNIT; k++) begin
      exp_env.push_back(lvl);
      exp_tx.push_back(lvl && (((k / CH) % 2) == 0));
    end
  endtask

  task automatic build_expect(input logic [31:0] raw, output int frame_len);
    exp_env.delete();
    exp_tx.delete();
    push_run(1'b1, 16);
    push_run(1'b0, 8);
    for (int b = 0; b < 32; b++) begin
      push_run(1'b1, 1);
      push_run(1'b0, raw[b] ? 3 : 1);
    end
    push_run(1'b1, 1);
    frame_len = exp_env.size();
    push_run(1'b0, GAP);
  endtask

  // Recover the data word from observed envelope run lengths (long space = 1).
  function automatic logic [31:0] decode(input logic q[$], input int flen);
    int runs[$];
    int len;
    logic [31:0] dec;
    dec = 32'h0;
    len = 1;
    for (int i = 1; i < flen; i++) begin
      if (q[i] == q[i-1]) len++;
      else begin
        runs.push_back(len);
        len = 1;
      end
    end
    runs.push_back(len);
    for (int b = 0; b < 32; b++)
      if (3 + 2 * b < runs.size()) dec[b] = (runs[3 + 2 * b] > 2 * UNIT);
    return dec;
  endfunction

  // Called just after a negedge. mode 0: drop valid; 1: random valid/code noise while busy;
  // 2: hold valid with next_code. Returns just after the negedge where ready is back.
  task automatic send_frame(input logic [31:0] code, input int mode, input logic [31:0] next_code);
    logic [32:0] m;
    int          flen, n, d0;
    logic [5:0]  obs_v, exp_v;
    logic        obs_q[$];
    m = map_code(code);
    build_expect(m[31:0], flen);
    n = 0;
    while (btn_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", {31'h0, btn_ready}, 32'h1);
    btn_valid = 1'b1;
    btn_code  = code;
    d0 = done_seen;
    for (int i = 1; i <= exp_env.size(); i++) begin
      @(negedge clk);
      obs_v = {ir_env, ir_tx, busy, btn_ready, frame_done, code_err};
      exp_v = {exp_env[i-1], exp_tx[i-1], 1'b1, 1'b0, (i == flen), 1'b0};
      check($sformatf("frame_%0h_cyc%0d", code, i), {26'h0, obs_v}, {26'h0, exp_v});
      obs_q.push_back(ir_env);
      case (mode)
        1: begin
          btn_valid = (i < exp_env.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
          btn_code  = $urandom;
        end
        2: begin
          btn_valid = 1'b1;
          btn_code  = next_code;
        end
        default: btn_valid = 1'b0;
      endcase
    end
    @(negedge clk);
    check($sformatf("frame_%0h_idle_again", code), {30'h0, busy, btn_ready}, 32'h1);
    check($sformatf("frame_%0h_done_count", code), 32'(done_seen - d0), 32'h1);
    check($sformatf("frame_%0h_decode", code), decode(obs_q, flen), m[31:0]);
  endtask

  task automatic send_bad(input logic [31:0] code);
    check($sformatf("bad_%0h_ready", code), {31'h0, btn_ready}, 32'h1);
    btn_valid = 1'b1;
    btn_code  = code;
    @(negedge clk);
    check($sformatf("bad_%0h_err", code),
          {26'h0, ir_env, ir_tx, busy, btn_ready, frame_done, code_err}, 32'b000101);
    btn_valid = 1'b0;
    @(negedge clk);
    check($sformatf("bad_%0h_after", code),
          {26'h0, ir_env, ir_tx, busy, btn_ready, frame_done, code_err}, 32'b000100);
  endtask

  initial begin
    logic [31:0] codes[8];
    logic [31:0] c;
    logic [32:0] m;
    int          d0;
    codes = '{32'h1, 32'h2, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA};

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", {26'h0, ir_env, ir_tx, busy, btn_ready, frame_done, code_err}, 32'h0);
    @(negedge clk);
    check("ready_low_in_reset", {31'h0, btn_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'h0, btn_ready}, 32'h1);

    // Single frame for code 0x1
    send_frame(32'h1, 0, 32'h0);

    // Unmappable codes
    send_bad(32'h3);
    send_bad(32'h1000_0001);
    send_bad(32'h0);

    // All codes back-to-back with valid held
    for (int k = 0; k < 8; k++)
      send_frame(codes[k], (k < 7) ? 2 : 0, codes[(k + 1) % 8]);

    // Random valid codes with input noise while busy
    for (int k = 0; k < 3; k++)
      send_frame(codes[$urandom_range(0, 7)], 1, 32'h0);

    // Random unmappable codes
    for (int k = 0; k < 3; k++) begin
      c = $urandom;
      m = map_code(c);
      while (m[32]) begin
        c = $urandom;
        m = map_code(c);
      end
      send_bad(c);
    end

    // Reset in the middle of bit 1's space of code 0xA
    btn_valid = 1'b1;
    btn_code  = 32'hA;
    d0 = done_seen;
    @(negedge clk);
    btn_valid = 1'b0;
    repeat (111) @(negedge clk);
    check("mid_space_state", {29'h0, ir_env, ir_tx, busy}, 32'b001);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {26'h0, ir_env, ir_tx, busy, btn_ready, frame_done, code_err}, 32'h0);
    @(negedge clk);
    check("held_reset_outputs",
          {26'h0, ir_env, ir_tx, busy, btn_ready, frame_done, code_err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", {30'h0, busy, btn_ready}, 32'h1);
    check("no_done_after_abort", 32'(done_seen - d0), 32'h0);
    send_frame(32'hA, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
